// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the BasicCPU control path: opcode constants,
//   the fetch/execute sequencer state encoding and the packed bundle of
//   bus/PC strobes that the sequencer drives.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_JZ  = 4'h3;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_F_ADDR = 3'd2,
    ST_F_DATA = 3'd3,
    ST_DECODE = 3'd4,
    ST_O_ADDR = 3'd5,
    ST_O_DATA = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  // MSB first: pc_reset is active-high, every other strobe active-low.
  typedef struct packed {
    logic pc_reset;
    logic pc_read_n;
    logic pc_write_n;
    logic pc_inc_n;
    logic mar_load_n;
    logic mem_read_n;
    logic ir_load_n;
    logic a_load_n;
  } strobes_t;

  // Every unit quiet: clear released, all active-low strobes high.
  localparam strobes_t STROBES_IDLE = strobes_t'(8'h7F);

endpackage

// File: rtl/pc_strobe_decode.sv
// pc_strobe_decode
//   Purely combinational map from (sequencer state, latched opcode, ALU zero)
//   to the strobe vector. At most one bus driver (PC or memory) and at most
//   one PC update (load or increment) is ever selected.
// Ports:
//   state_i    sequencer state encoding (cpu_pkg::state_t)
//   op_i       opcode latched on entry to O_ADDR
//   zero_i     ALU zero flag, only consulted in O_DATA for JZ
//   strobes_o  packed cpu_pkg::strobes_t
module pc_strobe_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [2:0]     state_i,
  input  logic [OPW-1:0] op_i,
  input  logic           zero_i,
  output logic [7:0]     strobes_o
);

  strobes_t s;

  always_comb begin
    s = STROBES_IDLE;
    case (state_t'(state_i))
      ST_CLEAR: s.pc_reset = 1'b1;
      ST_F_ADDR, ST_O_ADDR: begin
        s.pc_read_n  = 1'b0;
        s.mar_load_n = 1'b0;
      end
      ST_F_DATA: begin
        s.mem_read_n = 1'b0;
        s.ir_load_n  = 1'b0;
        s.pc_inc_n   = 1'b0;
      end
      ST_O_DATA: begin
        s.mem_read_n = 1'b0;
        if (op_i == OPW'(OP_LDA)) begin
          s.a_load_n = 1'b0;
          s.pc_inc_n = 1'b0;
        end else if (op_i == OPW'(OP_JMP)) begin
          s.pc_write_n = 1'b0;
        end else if (op_i == OPW'(OP_JZ)) begin
          // Taken branch loads the target, otherwise skip the operand byte.
          if (zero_i) s.pc_write_n = 1'b0;
          else        s.pc_inc_n   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign strobes_o = s;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch/execute sequencer for the BasicCPU datapath. Owns instruction
//   fetch, operand fetch, jumps and halt; drives PC, MAR, memory, IR and
//   accumulator strobes so that one source at a time drives the 8-bit bus.
//   Optional build macro PC_SEQUENCER_STEP_EN adds i_step: each rising edge
//   of i_step permits exactly one instruction.
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_run              execute enable, sampled at instruction boundaries
//   i_step             (PC_SEQUENCER_STEP_EN only) single-step request
//   i_ir               instruction register, opcode in the upper OPW bits
//   i_zero             ALU zero flag
//   o_pc_*             PC clear / drive / load / increment strobes
//   o_mar_load_n, o_mem_read_n, o_ir_load_n, o_a_load_n  bus unit strobes
//   o_halted           high in HALT
//   o_state            current state encoding for debug
//
// state  | meaning
// CLEAR  | PC clear pulse after reset
// IDLE   | waiting for i_run (and a step edge when stepping)
// F_ADDR | PC -> MAR
// F_DATA | mem -> IR, PC++
// DECODE | choose next step from opcode
// O_ADDR | PC -> MAR for the operand byte
// O_DATA | operand consumed by A or PC
// HALT   | stopped until reset
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_run,
`ifdef PC_SEQUENCER_STEP_EN
  input  logic       i_step,
`endif
  input  logic [7:0] i_ir,
  input  logic       i_zero,
  output logic       o_pc_reset,
  output logic       o_pc_read_n,
  output logic       o_pc_write_n,
  output logic       o_pc_inc_n,
  output logic       o_mar_load_n,
  output logic       o_mem_read_n,
  output logic       o_ir_load_n,
  output logic       o_a_load_n,
  output logic       o_halted,
  output logic [2:0] o_state
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [OPW-1:0] opcode;
  logic           go;
  strobes_t       strobes;

  assign opcode = i_ir[7 -: OPW];

  logic unused_ir;
  assign unused_ir = ^i_ir[7-OPW:0];

`ifdef PC_SEQUENCER_STEP_EN
  logic step_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) step_q <= 1'b0;
    else            step_q <= i_step;
  end

  assign go = i_run & i_step & ~step_q;
`else
  assign go = i_run;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_CLEAR:  state_d = ST_IDLE;
      ST_IDLE:   if (go) state_d = ST_F_ADDR;
      ST_F_ADDR: state_d = ST_F_DATA;
      ST_F_DATA: state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OPW'(OP_LDA) || opcode == OPW'(OP_JMP) ||
            opcode == OPW'(OP_JZ)) begin
          state_d = ST_O_ADDR;
          op_d    = opcode;
        end else if (opcode == OPW'(OP_HLT)) begin
          state_d = ST_HALT;
        end else begin
          // NOP and every unassigned opcode
          state_d = go ? ST_F_ADDR : ST_IDLE;
        end
      end
      ST_O_ADDR: state_d = ST_O_DATA;
      ST_O_DATA: state_d = go ? ST_F_ADDR : ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_CLEAR;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  pc_strobe_decode #(.OPW(OPW)) u_decode (
    .state_i   (state_q),
    .op_i      (op_q),
    .zero_i    (i_zero),
    .strobes_o (strobes)
  );

  assign o_pc_reset   = strobes.pc_reset;
  assign o_pc_read_n  = strobes.pc_read_n;
  assign o_pc_write_n = strobes.pc_write_n;
  assign o_pc_inc_n   = strobes.pc_inc_n;
  assign o_mar_load_n = strobes.mar_load_n;
  assign o_mem_read_n = strobes.mem_read_n;
  assign o_ir_load_n  = strobes.ir_load_n;
  assign o_a_load_n   = strobes.a_load_n;
  assign o_halted     = (state_q == ST_HALT);
  assign o_state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_run = 1'b0;
  logic       i_zero = 1'b0;
`ifdef PC_SEQUENCER_STEP_EN
  logic       i_step = 1'b0;
  logic       step_prev = 1'b0;
`endif
  logic [7:0] i_ir;
  logic       o_pc_reset, o_pc_read_n, o_pc_write_n, o_pc_inc_n;
  logic       o_mar_load_n, o_mem_read_n, o_ir_load_n, o_a_load_n, o_halted;
  logic [2:0] o_state;

  always #5 i_clk = ~i_clk;

  pc_sequencer #(.OPW(4)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_run        (i_run),
`ifdef PC_SEQUENCER_STEP_EN
    .i_step       (i_step),
`endif
    .i_ir         (i_ir),
    .i_zero       (i_zero),
    .o_pc_reset   (o_pc_reset),
    .o_pc_read_n  (o_pc_read_n),
    .o_pc_write_n (o_pc_write_n),
    .o_pc_inc_n   (o_pc_inc_n),
    .o_mar_load_n (o_mar_load_n),
    .o_mem_read_n (o_mem_read_n),
    .o_ir_load_n  (o_ir_load_n),
    .o_a_load_n   (o_a_load_n),
    .o_halted     (o_halted),
    .o_state      (o_state)
  );

  // Datapath environment driven by the DUT strobes.
  logic [7:0] mem [256];
  logic [7:0] pc = 8'h00, mar = 8'h00, ir = 8'h00, acc = 8'h00;
  logic [7:0] bus;
  assign bus  = !o_pc_read_n ? pc : (!o_mem_read_n ? mem[mar] : 8'h00);
  assign i_ir = ir;

  always @(posedge i_clk) begin
    if (o_pc_reset)         pc <= 8'h00;
    else if (!o_pc_write_n) pc <= bus;
    else if (!o_pc_inc_n)   pc <= pc + 8'h01;
    if (!o_mar_load_n) mar <= bus;
    if (!o_ir_load_n)  ir  <= bus;
    if (!o_a_load_n)   acc <= bus;
  end

  logic [11:0] dut_vec;
  assign dut_vec = {o_pc_reset, o_pc_read_n, o_pc_write_n, o_pc_inc_n, o_mar_load_n,
                    o_mem_read_n, o_ir_load_n, o_a_load_n, o_halted, o_state};

  // Strobes asserted (low) in a cycle, as a bitmask.
  localparam logic [6:0] L_RD  = 7'b1000000;
  localparam logic [6:0] L_WR  = 7'b0100000;
  localparam logic [6:0] L_INC = 7'b0010000;
  localparam logic [6:0] L_MAR = 7'b0001000;
  localparam logic [6:0] L_MEM = 7'b0000100;
  localparam logic [6:0] L_IR  = 7'b0000010;
  localparam logic [6:0] L_A   = 7'b0000001;

  function automatic logic [11:0] ev(state_t s, logic [6:0] low);
    return {(s == ST_CLEAR), ~low, (s == ST_HALT), s};
  endfunction

  typedef struct {
    logic [11:0] v;
    bit          last;  // instruction boundary: i_run decides what follows
  } ent_t;

  ent_t q[$];

  // ISA-level reference state
  logic [7:0] m_pc, m_a;
  bit         m_halt, a_valid, start_pending, run_drop;
  int         run_pol, zero_pol;  // run: 0 always,1 random,2 drop at O_ADDR; zero: 0,1,2=random
  int         tests = 0, fails = 0;
  int         cyc, halt_cyc, a_low_cnt;
  logic [7:0] a_bus;
  state_t     last_st;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(state_t s, logic [6:0] low, bit last);
    ent_t e;
    e.v = ev(s, low);
    e.last = last;
    q.push_back(e);
  endtask

  // Interpret one instruction at m_pc and queue its strobe schedule.
  task automatic start_instr();
    logic [3:0] op;
    logic [7:0] opd;
    bit         z;
    chk("pc_at_fetch", pc, m_pc);
    if (a_valid) chk("acc", acc, m_a);
    op = mem[m_pc][7:4];
    m_pc = m_pc + 8'h01;
    z = (zero_pol == 2) ? bit'($urandom_range(0, 1)) : bit'(zero_pol);
    i_zero = z;
    push(ST_F_ADDR, L_RD | L_MAR, 1'b0);
    push(ST_F_DATA, L_MEM | L_IR | L_INC, 1'b0);
    if (op == 4'h1 || op == 4'h2 || op == 4'h3) begin
      push(ST_DECODE, 7'h00, 1'b0);
      push(ST_O_ADDR, L_RD | L_MAR, 1'b0);
      opd = mem[m_pc];
      if (op == 4'h1) begin
        push(ST_O_DATA, L_MEM | L_A | L_INC, 1'b1);
        m_a = opd;
        a_valid = 1'b1;
        m_pc = m_pc + 8'h01;
      end else if (op == 4'h2 || z) begin
        push(ST_O_DATA, L_MEM | L_WR, 1'b1);
        m_pc = opd;
      end else begin
        push(ST_O_DATA, L_MEM | L_INC, 1'b1);
        m_pc = m_pc + 8'h01;
      end
    end else if (op == 4'hF) begin
      push(ST_DECODE, 7'h00, 1'b0);
      m_halt = 1'b1;
    end else begin
      push(ST_DECODE, 7'h00, 1'b1);
    end
  endtask

  task automatic one_cycle();
    ent_t e;
    @(negedge i_clk);
`ifdef PC_SEQUENCER_STEP_EN
    step_prev = i_step;
    i_step = ($urandom_range(0, 2) == 0);
`endif
    if (q.size() == 0) begin
      if (m_halt)             push(ST_HALT, 7'h00, 1'b0);
      else if (start_pending) start_instr();
      else                    push(ST_IDLE, 7'h00, 1'b1);
    end
    if (run_pol == 2 && q[0].v[2:0] == 3'(ST_O_ADDR)) run_drop = 1'b1;
    case (run_pol)
      0:       i_run = 1'b1;
      1:       i_run = ($urandom_range(0, 4) != 0);
      default: i_run = !run_drop;
    endcase
    #1;
    chk("outputs", dut_vec, q[0].v);
    chk("bus_owner", 32'(!o_pc_read_n && !o_mem_read_n), 0);
    chk("pc_update", 32'(!o_pc_write_n && !o_pc_inc_n), 0);
    if (!o_a_load_n) begin
      a_low_cnt++;
      a_bus = bus;
    end
    if (o_halted && halt_cyc < 0) halt_cyc = cyc;
    e = q.pop_front();
    last_st = state_t'(e.v[2:0]);
`ifdef PC_SEQUENCER_STEP_EN
    if (e.last) start_pending = i_run && i_step && !step_prev;
`else
    if (e.last) start_pending = i_run;
`endif
    cyc++;
  endtask

  task automatic apply_reset();
    #2;
    i_reset_n = 1'b0;
    i_run = 1'b0;
`ifdef PC_SEQUENCER_STEP_EN
    i_step = 1'b0;
`endif
    #1;
    chk("reset_async", dut_vec, ev(ST_CLEAR, 7'h00));
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    q.delete();
    push(ST_CLEAR, 7'h00, 1'b0);
    m_pc = 8'h00;
    m_halt = 1'b0;
    a_valid = 1'b0;
    start_pending = 1'b0;
    run_drop = 1'b0;
    cyc = 0;
    halt_cyc = -1;
    a_low_cnt = 0;
    a_bus = 8'h00;
  endtask

  task automatic fill_mem(logic [7:0] b);
    for (int i = 0; i < 256; i++) mem[i] = b;
  endtask

  task automatic rand_mem();
    int         r;
    logic [3:0] hi;
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 15));
      if (r < 4)       hi = 4'h0;
      else if (r < 7)  hi = 4'h1;
      else if (r < 10) hi = 4'h2;
      else if (r < 13) hi = 4'h3;
      else if (r < 14) hi = 4'hF;
      else             hi = 4'($urandom_range(4, 14));
      mem[i] = {hi, 4'($urandom)};
    end
  endtask

  task automatic run_prog(int n);
    apply_reset();
    repeat (n) one_cycle();
  endtask

  initial begin
    bit found;
    run_pol = 0;
    zero_pol = 0;

    // NOP, HLT
    fill_mem(8'hF0); mem[0] = 8'h00; mem[1] = 8'hF0;
    run_prog(40);
`ifndef PC_SEQUENCER_STEP_EN
    chk("halt_cycle", 32'(halt_cyc), 8);
`endif
    chk("nop_hlt_pc", pc, 8'h02);
    chk("nop_hlt_halted", 32'(o_halted), 1);

    // JMP 0x10, HLT at 0x10
    fill_mem(8'hF0); mem[0] = 8'h20; mem[1] = 8'h10;
    run_prog(40);
    chk("jmp_fetch_addr", mar, 8'h10);
    chk("jmp_pc", pc, 8'h11);

    // JZ 0x40 not taken / taken
    fill_mem(8'hF0); mem[0] = 8'h30; mem[1] = 8'h40;
    zero_pol = 0;
    run_prog(40);
    chk("jz_not_taken_pc", pc, 8'h03);
    zero_pol = 1;
    run_prog(40);
    chk("jz_taken_pc", pc, 8'h41);
    zero_pol = 0;

    // LDA #0x33
    fill_mem(8'hF0); mem[0] = 8'h10; mem[1] = 8'h33;
    run_prog(40);
    chk("lda_a_load_cycles", 32'(a_low_cnt), 1);
    chk("lda_bus", a_bus, 8'h33);
    chk("lda_acc", acc, 8'h33);
    chk("lda_pc", pc, 8'h03);

    // i_run dropped during O_ADDR of a JMP
    fill_mem(8'hF0); mem[0] = 8'h20; mem[1] = 8'h10;
    run_pol = 2;
    run_prog(20);
    chk("drop_run_pc", pc, 8'h10);
    chk("drop_run_state", 32'(o_state), 32'(ST_IDLE));
    run_pol = 0;

    // Reset asserted in the middle of F_DATA
    fill_mem(8'h00);
    apply_reset();
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      one_cycle();
      if (last_st == ST_F_DATA && cyc > 6) found = 1'b1;
    end
    chk("reach_f_data", 32'(found), 1);
    apply_reset();
    repeat (6) one_cycle();

    // Random programs, random i_run and i_zero
    run_pol = 1;
    zero_pol = 2;
    for (int p = 0; p < 30; p++) begin
      rand_mem();
      run_prog(150);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
